fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports as listed below (clock and reset first).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pc_addr  input  4  current program-counter value (q of the PC).
REQ-005 carry  input  1  ALU carry flag, sampled in EXEC.
REQ-006 run  input  1  level; 1 = execute program, 0 = return to IDLE.
REQ-007 prog_we  input  1  program-memory write strobe.
REQ-008 prog_addr  input  4  program-memory write address.
REQ-009 prog_data  input  8  program-memory write data.
REQ-010 instr  output  8  registered instruction word, with opcode in [7:4] and immediate in [3:0].
REQ-011 instr_valid  output  1  instr is valid for the current cycle.
REQ-012 pc_en  output  1  one-cycle PC advance strobe.
REQ-013 pc_load  output  1  with pc_en: PC loads pc_data instead of incrementing.
REQ-014 pc_data  output  4  jump target driven toward the PC data_in.
REQ-015 state  output  2  FSM encoding: IDLE=00, FETCH=01, EXEC=10, HALT=11.
REQ-016 halted  output  1  high while in HALT.

Function
REQ-017 SHALL contain a 16x8 program memory that is written on a clk edge when prog_we=1 and state=IDLE.
REQ-018 SHALL ignore prog_we when state is not IDLE.
REQ-019 IDLE: SHALL go to FETCH on the next edge when run=1; when prog_we and run are both high in the same cycle, the write completes and FETCH follows.
REQ-020 FETCH: SHALL register instr <= mem[pc_addr] and go to EXEC; instr_valid, pc_en and pc_load SHALL be 0.
REQ-021 EXEC: SHALL assert instr_valid=1 and pc_en=1 for exactly one cycle.
REQ-022 EXEC: SHALL assert pc_load=1 and pc_data=instr[3:0] when instr[7:4]=1111 (JMP).
REQ-023 EXEC: SHALL assert pc_load=1 and pc_data=instr[3:0] when instr[7:4]=1110 (JNC) and carry=0.
REQ-024 EXEC: for every other case, pc_load SHALL be 0 and pc_data SHALL be 0000.
REQ-025 EXEC: SHALL go to FETCH when run=1 and to IDLE when run=0; an EXEC already entered always completes.
REQ-026 FETCH with run=0: SHALL still perform the read and complete EXEC, then go to IDLE.
REQ-027 Steady run SHALL take 2 cycles per instruction, and pc_addr SHALL be stable from the FETCH edge on.
REQ-028 Address wrap (pc_addr 1111 -> 0000) SHALL be handled by the PC; this block treats every address uniformly.
REQ-029 instr SHALL hold its value in IDLE and HALT.

Reset
REQ-030 reset SHALL put the FSM in IDLE and drive instr=00000000, instr_valid=0, pc_en=0, pc_load=0, pc_data=0000, halted=0.
REQ-031 reset SHALL NOT clear program memory, so the contents survive reset.
REQ-032 reset asserted in FETCH or EXEC SHALL take priority over the pending transition, with no pc_en pulse on that edge.

Configuration
REQ-033 Macro FETCH_SEQ_HALT_DETECT_EN: when defined, EXEC with a JMP whose instr[3:0]==pc_addr SHALL enter HALT instead of FETCH; pc_en SHALL be 0 in that EXEC cycle; halted SHALL be 1 in HALT.
REQ-034 HALT SHALL exit only to IDLE when run=0, or on reset.
REQ-035 When FETCH_SEQ_HALT_DETECT_EN is undefined, HALT SHALL be unreachable, halted SHALL be tied to 0, and a self-JMP loops normally via FETCH/EXEC.

Verification
REQ-036 Load mem[0]=0x00, then run=1 with pc_addr=0 -> state 00->01->10, and in EXEC instr=0x00, instr_valid=1, pc_en=1, pc_load=0.
REQ-037 mem[3]=0xF9 (JMP 9), pc_addr=3 -> EXEC shows pc_load=1, pc_data=1001.
REQ-038 mem[5]=0xE2 (JNC 2): with carry=0 -> pc_load=1, pc_data=0010; with carry=1 -> pc_load=0, pc_data=0000.
REQ-039 prog_we=1, addr=4, data=0xAA while in FETCH -> mem[4] is unchanged (a later fetch at 4 returns the prior value).
REQ-040 reset asserted mid-EXEC -> next cycle state=00, pc_en=0, and memory contents are intact on re-run.
REQ-041 With FETCH_SEQ_HALT_DETECT_EN defined, mem[7]=0xF7 and pc_addr=7 -> state=11, halted=1, pc_en=0; then run=0 -> state=00.

Source files
------------

// File: rtl/fetch_seq.sv
// fetch_seq: fetch/execute sequencer with a 16x8 program memory.
//
// The program memory is loaded through the prog_* port while the sequencer
// is idle. With run high, the sequencer alternates FETCH and EXEC, taking two
// cycles per instruction. FETCH registers mem[pc_addr] into instr. EXEC
// presents the word on instr, pulses pc_en, and requests a PC load for JMP
// (opcode 1111), or for JNC (opcode 1110) when carry is clear.
//
// Optional feature: macro FETCH_SEQ_HALT_DETECT_EN. When it is defined, a JMP
// to its own address parks the sequencer in HALT instead of looping. When it
// is not defined, HALT cannot be reached and halted is always 0.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high reset (program memory is not cleared)
//   pc_addr     current PC value; the fetch address
//   carry       ALU carry flag, sampled during EXEC
//   run         level: 1 = execute, 0 = return to IDLE
//   prog_we     program-memory write strobe (acts only in IDLE)
//   prog_addr   program-memory write address
//   prog_data   program-memory write data
//   instr       registered instruction: opcode [7:4], immediate [3:0]
//   instr_valid high for the EXEC cycle
//   pc_en       one-cycle PC advance strobe (EXEC)
//   pc_load     with pc_en: the PC loads pc_data instead of incrementing
//   pc_data     jump target; 0000 when no load is requested
//   state       IDLE=00, FETCH=01, EXEC=10, HALT=11
//   halted      high while in HALT
module fetch_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] pc_addr,
    input  logic       carry,
    input  logic       run,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [7:0] instr,
    output logic       instr_valid,
    output logic       pc_en,
    output logic       pc_load,
    output logic [3:0] pc_data,
    output logic [1:0] state,
    output logic       halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    localparam logic [3:0] OP_JMP = 4'b1111;
    localparam logic [3:0] OP_JNC = 4'b1110;

    state_t     st;
    logic [7:0] mem [16];
    logic [7:0] rd_word;
    logic       self_jmp_rd;   // word being fetched is a JMP to its own address
    logic       halt_pend;     // the instruction now in EXEC is a self-JMP

    assign rd_word = mem[pc_addr];

`ifdef FETCH_SEQ_HALT_DETECT_EN
    assign self_jmp_rd = (rd_word[7:4] == OP_JMP) && (rd_word[3:0] == pc_addr);
`else
    assign self_jmp_rd = 1'b0;
`endif

    // The program memory has no reset, so a program loaded once survives reset.
    always_ff @(posedge clk) begin
        if (prog_we && st == S_IDLE)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= S_IDLE;
            instr       <= 8'h00;
            instr_valid <= 1'b0;
            pc_en       <= 1'b0;
            halt_pend   <= 1'b0;
            halted      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            pc_en       <= 1'b0;
            halt_pend   <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (run)
                        st <= S_FETCH;
                end
                // The fetch always completes, even if run has dropped.
                // A self-JMP suppresses pc_en because the sequencer parks in HALT.
                S_FETCH: begin
                    instr       <= rd_word;
                    instr_valid <= 1'b1;
                    pc_en       <= ~self_jmp_rd;
                    halt_pend   <= self_jmp_rd;
                    st          <= S_EXEC;
                end
                S_EXEC: begin
                    if (!run)
                        st <= S_IDLE;
                    else if (halt_pend) begin
                        st     <= S_HALT;
                        halted <= 1'b1;
                    end else
                        st <= S_FETCH;
                end
                S_HALT: begin
                    if (!run) begin
                        st     <= S_IDLE;
                        halted <= 1'b0;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    // The load request is decoded from the registered instruction during EXEC.
    // It is combinational so that JNC sees the carry value of the EXEC cycle.
    always_comb begin
        pc_load = 1'b0;
        pc_data = 4'b0000;
        if (st == S_EXEC &&
            (instr[7:4] == OP_JMP || (instr[7:4] == OP_JNC && !carry))) begin
            pc_load = 1'b1;
            pc_data = instr[3:0];
        end
    end

    assign state = st;

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pc_addr;
    logic       carry;
    logic       run;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] instr;
    logic       instr_valid;
    logic       pc_en;
    logic       pc_load;
    logic [3:0] pc_data;
    logic [1:0] state;
    logic       halted;

    fetch_seq dut (
        .clk(clk), .reset(reset), .pc_addr(pc_addr), .carry(carry), .run(run),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instr(instr), .instr_valid(instr_valid), .pc_en(pc_en),
        .pc_load(pc_load), .pc_data(pc_data), .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    logic [7:0] mdl [16];   // reference copy of the program memory

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected load request from the instruction-set rules.
    function automatic logic want_load(input logic [7:0] w, input logic c);
        return (w[7:4] == 4'hF) || (w[7:4] == 4'hE && !c);
    endfunction

    // Random word that is never a JMP to its own address.
    function automatic logic [7:0] rnd_word(input logic [3:0] a);
        logic [7:0] w;
        w = 8'($urandom);
        if (w[7:4] == 4'hF && w[3:0] == a) w[3:0] = a + 4'd1;
        return w;
    endfunction

    task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step();
        prog_we = 1'b0;
        mdl[a] = d;
    endtask

    // One instruction started from IDLE. run drops during FETCH, and the
    // sequencer must still finish EXEC and then return to IDLE. With junk set,
    // a write is attempted during FETCH and must be ignored.
    task automatic run_one(input logic [3:0] a, input logic c, input logic junk);
        logic [7:0] w;
        logic       ld;
        w  = mdl[a];
        ld = want_load(w, c);
        pc_addr = a; carry = c; run = 1'b1;
        step();
        chk("fetch_state", 8'(state), 8'd1);
        chk("fetch_pcen", 8'(pc_en), 8'd0);
        chk("fetch_valid", 8'(instr_valid), 8'd0);
        if (junk) begin
            prog_we = 1'b1; prog_addr = a; prog_data = ~w;
        end
        run = 1'b0;
        step();
        prog_we = 1'b0;
        chk("exec_state", 8'(state), 8'd2);
        chk("exec_instr", instr, w);
        chk("exec_valid", 8'(instr_valid), 8'd1);
        chk("exec_pcen", 8'(pc_en), 8'd1);
        chk("exec_pcload", 8'(pc_load), 8'(ld));
        chk("exec_pcdata", 8'(pc_data), ld ? 8'(w[3:0]) : 8'd0);
        step();
        chk("idle_state", 8'(state), 8'd0);
        chk("idle_instr_hold", instr, w);
        chk("idle_pcen", 8'(pc_en), 8'd0);
    endtask

    // Continuous run of n instructions. The bench acts as the PC: it follows
    // pc_en/pc_load and presents the new address at the start of each FETCH.
    task automatic run_steady(input logic [3:0] start, input int n);
        logic [3:0] pc;
        logic [7:0] w;
        logic       ld;
        pc = start; pc_addr = pc; carry = 1'($urandom); run = 1'b1;
        step();
        chk("st_fetch0", 8'(state), 8'd1);
        for (int k = 0; k < n; k++) begin
            step();
            w  = mdl[pc];
            ld = want_load(w, carry);
            chk("st_exec", 8'(state), 8'd2);
            chk("st_instr", instr, w);
            chk("st_pcen", 8'(pc_en), 8'd1);
            chk("st_pcload", 8'(pc_load), 8'(ld));
            chk("st_pcdata", 8'(pc_data), ld ? 8'(w[3:0]) : 8'd0);
            pc = ld ? w[3:0] : pc + 4'd1;
            if (k == n - 1) run = 1'b0;
            step();
            chk("st_next", 8'(state), (k == n - 1) ? 8'd0 : 8'd1);
            chk("st_pcen_off", 8'(pc_en), 8'd0);
            pc_addr = pc; carry = 1'($urandom);
        end
    endtask

    initial begin
        logic [7:0] w;
        reset = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = 4'd0;
        prog_data = 8'd0; pc_addr = 4'd0; carry = 1'b0;
        step(); step();
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_instr", instr, 8'h00);
        chk("rst_valid", 8'(instr_valid), 8'd0);
        chk("rst_pcen", 8'(pc_en), 8'd0);
        chk("rst_pcload", 8'(pc_load), 8'd0);
        chk("rst_pcdata", 8'(pc_data), 8'd0);
        chk("rst_halted", 8'(halted), 8'd0);
        reset = 1'b0;

        // Load a random program with the directed words in place.
        for (int i = 0; i < 16; i++) begin
            w = rnd_word(4'(i));
            if (i == 0) w = 8'h00;
            if (i == 3) w = 8'hF9;
            if (i == 5) w = 8'hE2;
            write_mem(4'(i), w);
        end
        chk("load_idle", 8'(state), 8'd0);

        run_one(4'd0, 1'b0, 1'b0);   // NOP
        run_one(4'd3, 1'b1, 1'b0);   // JMP 9
        run_one(4'd5, 1'b0, 1'b0);   // JNC 2, taken
        run_one(4'd5, 1'b1, 1'b0);   // JNC 2, not taken
        run_one(4'd4, 1'b0, 1'b1);   // write during FETCH is ignored
        run_one(4'd4, 1'b1, 1'b0);   // ...and the old word is still there

        // A write and run in the same IDLE cycle: the write lands, then FETCH.
        w = rnd_word(4'd9);
        pc_addr = 4'd9; prog_we = 1'b1; prog_addr = 4'd9; prog_data = w; run = 1'b1;
        step();
        prog_we = 1'b0; mdl[9] = w;
        chk("wr_run_state", 8'(state), 8'd1);
        run = 1'b0;
        step();
        chk("wr_run_instr", instr, w);
        step();

        for (int i = 0; i < 20; i++)
            run_one(4'($urandom), 1'($urandom), 1'($urandom));

        run_steady(4'd14, 12);        // covers the 1111 -> 0000 wrap
        for (int i = 0; i < 3; i++)
            run_steady(4'($urandom), 10);

        // Reset during FETCH: reset wins, and pc_en does not pulse.
        pc_addr = 4'd3; run = 1'b1;
        step();
        reset = 1'b1;
        step();
        chk("rstf_state", 8'(state), 8'd0);
        chk("rstf_pcen", 8'(pc_en), 8'd0);
        reset = 1'b0; run = 1'b0;
        step();

        // Reset during EXEC, then check that memory survived.
        pc_addr = 4'd3; run = 1'b1;
        step(); step();
        chk("rste_pre", 8'(state), 8'd2);
        reset = 1'b1;
        step();
        chk("rste_state", 8'(state), 8'd0);
        chk("rste_pcen", 8'(pc_en), 8'd0);
        chk("rste_instr", instr, 8'h00);
        reset = 1'b0; run = 1'b0;
        step();
        run_one(4'd3, 1'b0, 1'b0);
        run_one(4'd5, 1'b0, 1'b0);

        // Self-JMP at address 7.
        write_mem(4'd7, 8'hF7);
        pc_addr = 4'd7; run = 1'b1; carry = 1'b0;
        step(); step();
        chk("sj_exec", 8'(state), 8'd2);
        chk("sj_pcload", 8'(pc_load), 8'd1);
        chk("sj_pcdata", 8'(pc_data), 8'd7);
`ifdef FETCH_SEQ_HALT_DETECT_EN
        chk("sj_pcen", 8'(pc_en), 8'd0);
        step();
        chk("halt_state", 8'(state), 8'd3);
        chk("halt_flag", 8'(halted), 8'd1);
        chk("halt_pcen", 8'(pc_en), 8'd0);
        step();
        chk("halt_stay", 8'(state), 8'd3);
        chk("halt_instr", instr, 8'hF7);
        run = 1'b0;
        step();
        chk("halt_exit", 8'(state), 8'd0);
        chk("halt_clear", 8'(halted), 8'd0);
`else
        chk("sj_pcen", 8'(pc_en), 8'd1);
        step();
        chk("sj_loop", 8'(state), 8'd1);
        chk("sj_halted", 8'(halted), 8'd0);
        step();
        chk("sj_loop2", 8'(state), 8'd2);
        chk("sj_pcen2", 8'(pc_en), 8'd1);
        run = 1'b0;
        step();
        chk("sj_idle", 8'(state), 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
